fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 8 +
 rtl/fetch_perf_cnt.sv | 27 ++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its optional perf counters.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // Branch targets are forced onto a word boundary; low bits are dropped silently.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and a combinational-read memory (slave).
interface fetch_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;

  modport master (output imem_addr_o, input imem_rdata_i);
  modport slave  (input imem_addr_o, output imem_rdata_i);
endinterface

// File: rtl/fetch_perf_cnt.sv
// Free-running fetch/flush event counters, wrapping at 2^32; used only with FETCH_PERF_CNT_EN.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fetch_inc,
  input  logic        i_flush_inc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_flush_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (i_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_flush_inc) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, stall and EX redirect handling.
// Optional perf counters (fetch_cnt_o, flush_cnt_o) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  fetch_if.master     imem,
  output logic [31:0] instr_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] PCplus4_ID,
  output logic        valid_ID,
  output logic        flush_EX_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_id;
  logic [31:0]  r_pcplus4_id;
  logic         r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc_id      <= 32'd0;
      r_pcplus4_id <= 32'd0;
      r_valid      <= 1'b0;
    end else if (redirect_i) begin
      r_state      <= RUN;
      r_pc         <= word_align(redirect_pc_i);
      r_instr      <= NOP_INSTR;
      r_pc_id      <= 32'd0;
      r_pcplus4_id <= 32'd4;
      r_valid      <= 1'b0;
    end else if (stall_i) begin
      r_state <= HOLD;
    end else begin
      r_state <= RUN;
      if (r_state == BOOT) begin
        // First cycle out of reset: memory is addressed but nothing is handed to decode yet.
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else begin
        r_pc         <= r_pc + 32'd4;
        r_instr      <= imem.imem_rdata_i;
        r_pc_id      <= r_pc;
        r_pcplus4_id <= r_pc + 32'd4;
        r_valid      <= 1'b1;
      end
    end
  end

  assign imem.imem_addr_o = r_pc;
  assign instr_ID         = r_instr;
  assign PC_ID            = r_pc_id;
  assign PCplus4_ID       = r_pcplus4_id;
  assign valid_ID         = r_valid;
  assign flush_EX_o       = redirect_i;

`ifdef FETCH_PERF_CNT_EN
  logic w_fetch_inc;
  logic w_flush_inc;

  assign w_fetch_inc = !reset && !redirect_i && !stall_i && (r_state != BOOT);
  assign w_flush_inc = !reset && redirect_i;

  fetch_perf_cnt u_perf_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_fetch_inc (w_fetch_inc),
    .i_flush_inc (w_flush_inc),
    .o_fetch_cnt (fetch_cnt_o),
    .o_flush_cnt (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect/reset traffic.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_ID;
  logic [31:0] PC_ID;
  logic [31:0] PCplus4_ID;
  logic        valid_ID;
  logic        flush_EX_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  fetch_if bus ();

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.imem_rdata_i = mem_word(bus.imem_addr_o);

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (bus.master),
    .instr_ID      (instr_ID),
    .PC_ID         (PC_ID),
    .PCplus4_ID    (PCplus4_ID),
    .valid_ID      (valid_ID),
    .flush_EX_o    (flush_EX_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: fetch address plus the word currently presented to decode.
  logic [31:0] m_pc, m_instr, m_pcid, m_pcp4;
  logic        m_valid;
  bit          m_boot;
  logic [31:0] m_fetch, m_flush;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_pc = RST_PC; m_instr = NOP; m_pcid = 0; m_pcp4 = 0; m_valid = 0;
      m_boot = 1; m_fetch = 0; m_flush = 0;
    end else if (redirect_i) begin
      m_pc = redirect_pc_i & 32'hFFFF_FFFC;
      m_instr = NOP; m_pcid = 0; m_pcp4 = 4; m_valid = 0;
      m_boot = 0; m_flush = m_flush + 1;
    end else if (stall_i) begin
      m_boot = 0;
    end else if (m_boot) begin
      m_instr = NOP; m_valid = 0; m_boot = 0;
    end else begin
      m_instr = mem_word(m_pc); m_pcid = m_pc; m_pcp4 = m_pc + 4; m_valid = 1;
      m_pc = m_pc + 4; m_fetch = m_fetch + 1;
    end
  endtask

  // One clock: flush checked against the driven redirect, then all registered outputs vs model.
  task automatic step();
    #1;
    if (!reset) check_val("flush_EX", {31'd0, flush_EX_o}, {31'd0, redirect_i});
    model_update();
    @(posedge clk);
    #1;
    check_val("imem_addr", bus.imem_addr_o, m_pc);
    check_val("instr_ID", instr_ID, m_instr);
    check_val("PC_ID", PC_ID, m_pcid);
    check_val("PCplus4_ID", PCplus4_ID, m_pcp4);
    check_val("valid_ID", {31'd0, valid_ID}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    check_val("fetch_cnt", fetch_cnt_o, m_fetch);
    check_val("flush_cnt", flush_cnt_o, m_flush);
`endif
  endtask

  task automatic drive(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt);
    reset = rst; stall_i = stl; redirect_i = rdr; redirect_pc_i = tgt;
  endtask

  initial begin
    drive(1, 0, 0, 0);
    @(posedge clk); #1;
    step(); step();
    check_val("rst_valid", {31'd0, valid_ID}, 32'd0);
    check_val("rst_instr", instr_ID, NOP);
    check_val("rst_pcid", PC_ID, 32'd0);
    check_val("rst_addr", bus.imem_addr_o, RST_PC);
    $display("reset: addr=%h instr=%h valid=%0b", bus.imem_addr_o, instr_ID, valid_ID);

    drive(0, 0, 0, 0);
    step();
    check_val("boot_valid", {31'd0, valid_ID}, 32'd0);
    check_val("boot_instr", instr_ID, NOP);
    step();
    check_val("c2_pcid", PC_ID, 32'd0);
    check_val("c2_valid", {31'd0, valid_ID}, 32'd1);
    step();
    check_val("c3_pcid", PC_ID, 32'd4);
    check_val("c3_pcp4", PCplus4_ID, 32'd8);
    step();
    $display("startup: PC_ID=%h PCplus4_ID=%h", PC_ID, PCplus4_ID);

    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_pcid", PC_ID, 32'd8);
      check_val("stall_instr", instr_ID, mem_word(32'd8));
      check_val("stall_addr", bus.imem_addr_o, 32'd12);
    end
    drive(0, 0, 0, 0);
    step();
    check_val("unstall_pcid", PC_ID, 32'd12);
    $display("stall: released PC_ID=%h", PC_ID);

    drive(0, 0, 1, 32'h40);
    #1 check_val("redir_flush", {31'd0, flush_EX_o}, 32'd1);
    step();
    check_val("redir_valid", {31'd0, valid_ID}, 32'd0);
    check_val("redir_addr", bus.imem_addr_o, 32'h40);
    drive(0, 0, 0, 0);
    step();
    check_val("redir_pcid", PC_ID, 32'h40);
    $display("redirect: PC_ID=%h", PC_ID);

    drive(0, 1, 1, 32'h23);
    step();
    check_val("redir_stall_addr", bus.imem_addr_o, 32'h20);
    drive(0, 0, 0, 0);
    step();
    $display("redirect+stall: PC_ID=%h", PC_ID);

    drive(0, 0, 1, 32'hFFFF_FFFC);
    step();
    drive(0, 0, 0, 0);
    step();
    check_val("wrap_addr", bus.imem_addr_o, 32'h0);
    check_val("wrap_pcid", PC_ID, 32'hFFFF_FFFC);
    check_val("wrap_pcp4", PCplus4_ID, 32'h0);
    $display("wrap: addr=%h PCplus4_ID=%h", bus.imem_addr_o, PCplus4_ID);

    drive(0, 1, 0, 0);
    step(); step();
    drive(1, 1, 1, 32'h80);
    step();
    check_val("hold_rst_addr", bus.imem_addr_o, RST_PC);
    check_val("hold_rst_valid", {31'd0, valid_ID}, 32'd0);
    $display("reset in hold: addr=%h", bus.imem_addr_o);

`ifdef FETCH_PERF_CNT_EN
    drive(0, 0, 0, 0);
    step();
    for (int i = 0; i < 10; i++) step();
    drive(0, 0, 1, 32'h100);
    step(); step();
    check_val("cnt_fetch", fetch_cnt_o, 32'd10);
    check_val("cnt_flush", flush_cnt_o, 32'd2);
    $display("counters: fetch=%0d flush=%0d", fetch_cnt_o, flush_cnt_o);
    drive(1, 0, 0, 0);
    step();
`endif

    drive(0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(99) == 0),
            m_boot ? 1'b0 : ($urandom_range(3) == 0),
            ($urandom_range(9) == 0),
            $urandom);
      step();
    end
    $display("random: %0d cycles done", 2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
